// File: rtl/hit_window_monitor.sv
// hit_window_monitor: counts detector hits over windows of WINDOW enabled cycles and
// publishes count/alarm/drop through a one-deep valid/ready report buffer.
module hit_window_monitor #(
    parameter int WINDOW = 64,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hit_in,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_alarm,
    output logic             rpt_drop,
    output logic             busy
);
    localparam int WCNT_W = $clog2(WINDOW);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d, cnt_q, cnt_d, closed;
    logic [CNT_W:0]    sum;
    logic              vld_q, vld_d, alarm_q, alarm_d, drop_q, drop_d, pend_q, pend_d;
    logic              close, load;

    // IDLE keeps wcnt/acc at zero, so a window opening from IDLE needs no special case
    always_comb begin
        sum     = {1'b0, acc_q} + (CNT_W+1)'(hit_in);
        closed  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        close   = en && (wcnt_q == WCNT_W'(WINDOW - 1));
        load    = close && (!vld_q || rpt_ready);
        state_d = en ? RUN : IDLE;
        wcnt_d  = (en && !close) ? wcnt_q + 1'b1 : '0;
        acc_d   = (en && !close) ? closed : '0;
        vld_d   = load || (vld_q && !rpt_ready);
        cnt_d   = load ? closed : cnt_q;
        alarm_d = load ? (closed >= CNT_W'(THRESH)) : alarm_q;
        drop_d  = load ? pend_q : drop_q;
        pend_d  = close ? !load : pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            drop_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
        end
    end

    assign rpt_valid = vld_q;
    assign rpt_count = cnt_q;
    assign rpt_alarm = alarm_q;
    assign rpt_drop  = drop_q;
    assign busy      = (state_q == RUN);
endmodule
